// File: rtl/uart_hex_frame_parser_if.sv
// uart_hex_frame_parser_if
//   Bundles the byte-stream input and the decoded-word output of the ASCII-hex
//   frame parser.
//   slave  : the parser side (consumes bytes, drives decoded fields)
//   master : the host/UART side (drives bytes, observes decoded fields)
//   Signals:
//     i_byte_available  one-cycle strobe, i_byte valid
//     i_byte            received ASCII character
//     o_command         decoded command field
//     o_address         decoded address field
//     o_data            current decoded data word
//     o_data_count      words remaining after the current one
//     o_ready           one-cycle pulse, decoded fields valid
//     o_error           one-cycle pulse on frame abort
//     o_error_code      1=non-hex, 2=timeout, 3=resync; held until next error
//     o_busy            parser is inside a frame
interface uart_hex_frame_parser_if #(
  parameter int unsigned COUNT_NIBBLES = 7,
  parameter int unsigned CMD_NIBBLES   = 8,
  parameter int unsigned ADDR_NIBBLES  = 8,
  parameter int unsigned DATA_NIBBLES  = 8
);
  logic                         i_byte_available;
  logic [7:0]                   i_byte;
  logic [4*CMD_NIBBLES-1:0]     o_command;
  logic [4*ADDR_NIBBLES-1:0]    o_address;
  logic [4*DATA_NIBBLES-1:0]    o_data;
  logic [4*COUNT_NIBBLES-1:0]   o_data_count;
  logic                         o_ready;
  logic                         o_error;
  logic [1:0]                   o_error_code;
  logic                         o_busy;

  modport slave (
    input  i_byte_available, i_byte,
    output o_command, o_address, o_data, o_data_count,
    output o_ready, o_error, o_error_code, o_busy
  );

  modport master (
    output i_byte_available, i_byte,
    input  o_command, o_address, o_data, o_data_count,
    input  o_ready, o_error, o_error_code, o_busy
  );
endinterface

// File: rtl/uart_hex_frame_parser.sv
// uart_hex_frame_parser
//   Turns an ASCII-hex byte stream into count/command/address/data words.
//   Frame: START_CHAR, COUNT_NIBBLES count digits, CMD_NIBBLES command digits,
//   ADDR_NIBBLES address digits, then (count + 1) words of DATA_NIBBLES digits.
//   Each completed data word produces a one-cycle o_ready, with o_data_count
//   holding the number of words still to come. Non-hex bytes, a START_CHAR
//   inside a frame, and inter-byte idle of TIMEOUT clocks abort the frame
//   with a one-cycle o_error and a sticky o_error_code.
//   Ports:
//     i_clk   system clock
//     i_rst   synchronous active-low reset
//     io_bus  byte input / decoded output bundle (slave side)
module uart_hex_frame_parser #(
  parameter int unsigned COUNT_NIBBLES = 7,
  parameter int unsigned CMD_NIBBLES   = 8,
  parameter int unsigned ADDR_NIBBLES  = 8,
  parameter int unsigned DATA_NIBBLES  = 8,
  parameter logic [7:0]  START_CHAR    = 8'h4C,
  parameter int unsigned TIMEOUT       = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  uart_hex_frame_parser_if.slave  io_bus
);

  localparam int unsigned NW = 4 * COUNT_NIBBLES;
  localparam int unsigned CW = 4 * CMD_NIBBLES;
  localparam int unsigned AW = 4 * ADDR_NIBBLES;
  localparam int unsigned DW = 4 * DATA_NIBBLES;

  localparam int unsigned MaxA   = (COUNT_NIBBLES > CMD_NIBBLES) ? COUNT_NIBBLES : CMD_NIBBLES;
  localparam int unsigned MaxB   = (ADDR_NIBBLES > DATA_NIBBLES) ? ADDR_NIBBLES : DATA_NIBBLES;
  localparam int unsigned MaxNib = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned NCW    = (MaxNib > 1) ? $clog2(MaxNib) : 1;

  localparam logic [NCW-1:0] CountLast = NCW'(COUNT_NIBBLES - 1);
  localparam logic [NCW-1:0] CmdLast   = NCW'(CMD_NIBBLES - 1);
  localparam logic [NCW-1:0] AddrLast  = NCW'(ADDR_NIBBLES - 1);
  localparam logic [NCW-1:0] DataLast  = NCW'(DATA_NIBBLES - 1);

  // Timer holds 0..TIMEOUT-1; the abort fires on the clock it would reach TIMEOUT.
  localparam int unsigned    TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TimerLast = TW'(TIMEOUT - 1);
  localparam bit             TimeoutEn = (TIMEOUT != 0);

  localparam logic [1:0] ErrNonHex  = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
  localparam logic [1:0] ErrResync  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StCommand,
    StAddress,
    StData
  } state_e;

  state_e           r_state;
  logic [NW-1:0]    r_count;       // count field, then remaining-word counter
  logic [CW-1:0]    r_cmd;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_data_sh;     // data word being assembled
  logic [DW-1:0]    r_data;        // last completed data word
  logic [NW-1:0]    r_data_count;
  logic [NCW-1:0]   r_nib;
  logic [TW-1:0]    r_timer;
  logic             r_ready;
  logic             r_error;
  logic [1:0]       r_error_code;

  logic             w_is_hex;
  logic [3:0]       w_nib;
  logic             w_is_start;
  logic [NW-1:0]    w_count_sh;
  logic [CW-1:0]    w_cmd_sh;
  logic [AW-1:0]    w_addr_sh;
  logic [DW-1:0]    w_data_sh;

  // ASCII hex decode; 'A'/'a' have low nibble 1, so add 9 to get 10.
  always_comb begin
    w_is_hex = 1'b1;
    w_nib    = 4'd0;
    if (io_bus.i_byte >= 8'h30 && io_bus.i_byte <= 8'h39) begin
      w_nib = io_bus.i_byte[3:0];
    end else if ((io_bus.i_byte >= 8'h41 && io_bus.i_byte <= 8'h46) ||
                 (io_bus.i_byte >= 8'h61 && io_bus.i_byte <= 8'h66)) begin
      w_nib = io_bus.i_byte[3:0] + 4'd9;
    end else begin
      w_is_hex = 1'b0;
    end
  end

  assign w_is_start = (io_bus.i_byte == START_CHAR);
  assign w_count_sh = (r_count << 4) | NW'(w_nib);
  assign w_cmd_sh   = (r_cmd << 4) | CW'(w_nib);
  assign w_addr_sh  = (r_addr << 4) | AW'(w_nib);
  assign w_data_sh  = (r_data_sh << 4) | DW'(w_nib);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_count      <= '0;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_data_sh    <= '0;
      r_data       <= '0;
      r_data_count <= '0;
      r_nib        <= '0;
      r_timer      <= '0;
      r_ready      <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= 2'd0;
    end else begin
      r_ready <= 1'b0;
      r_error <= 1'b0;

      if (io_bus.i_byte_available) begin
        // A consumed byte always restarts the idle timer, even on the
        // clock the timer would otherwise have expired.
        r_timer <= '0;
        if (w_is_start) begin
          // Start character always opens a fresh frame; inside a frame it
          // also reports the abandoned one.
          r_count      <= '0;
          r_cmd        <= '0;
          r_addr       <= '0;
          r_data_sh    <= '0;
          r_data       <= '0;
          r_data_count <= '0;
          r_nib        <= '0;
          r_state      <= StCount;
          if (r_state != StIdle) begin
            r_error      <= 1'b1;
            r_error_code <= ErrResync;
          end
        end else if (r_state == StIdle) begin
          // Noise between frames (CR/LF etc.) is dropped silently.
        end else if (!w_is_hex) begin
          r_error      <= 1'b1;
          r_error_code <= ErrNonHex;
          r_nib        <= '0;
          r_state      <= StIdle;
        end else begin
          case (r_state)
            StCount: begin
              r_count <= w_count_sh;
              if (r_nib == CountLast) begin
                r_nib   <= '0;
                r_state <= StCommand;
              end else begin
                r_nib <= r_nib + NCW'(1);
              end
            end
            StCommand: begin
              r_cmd <= w_cmd_sh;
              if (r_nib == CmdLast) begin
                r_nib   <= '0;
                r_state <= StAddress;
              end else begin
                r_nib <= r_nib + NCW'(1);
              end
            end
            StAddress: begin
              r_addr <= w_addr_sh;
              if (r_nib == AddrLast) begin
                r_nib   <= '0;
                r_state <= StData;
              end else begin
                r_nib <= r_nib + NCW'(1);
              end
            end
            StData: begin
              if (r_nib == DataLast) begin
                r_data       <= w_data_sh;
                r_data_count <= r_count;
                r_ready      <= 1'b1;
                r_data_sh    <= '0;
                r_nib        <= '0;
                if (r_count != '0) begin
                  r_count <= r_count - NW'(1);
                end else begin
                  r_state <= StIdle;
                end
              end else begin
                r_data_sh <= w_data_sh;
                r_nib     <= r_nib + NCW'(1);
              end
            end
            default: r_state <= StIdle;
          endcase
        end
      end else if (r_state != StIdle) begin
        if (TimeoutEn && (r_timer == TimerLast)) begin
          r_error      <= 1'b1;
          r_error_code <= ErrTimeout;
          r_nib        <= '0;
          r_timer      <= '0;
          r_state      <= StIdle;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end else begin
        r_timer <= '0;
      end
    end
  end

  assign io_bus.o_command    = r_cmd;
  assign io_bus.o_address    = r_addr;
  assign io_bus.o_data       = r_data;
  assign io_bus.o_data_count = r_data_count;
  assign io_bus.o_ready      = r_ready;
  assign io_bus.o_error      = r_error;
  assign io_bus.o_error_code = r_error_code;
  assign io_bus.o_busy       = (r_state != StIdle);

endmodule

// File: doc/uart_hex_frame_parser.md
Name: uart_hex_frame_parser

Overview:
Parametrised next-generation UART host-interface input handler. Converts a received ASCII-hex byte stream (one byte per byte_available strobe from the UART receiver) into command/address/data words for the wishbone master. It extends the fixed 32-bit single-word handler with configurable field widths, multi-word burst delivery, error reporting, an inter-byte timeout, and start-character resynchronisation.

Parameters:
COUNT_NIBBLES, 7, hex digits in data-count field (count width = 4*COUNT_NIBBLES)
CMD_NIBBLES, 8, hex digits in command field
ADDR_NIBBLES, 8, hex digits in address field
DATA_NIBBLES, 8, hex digits per data word
START_CHAR, 8'h4C, frame start character ('L')
TIMEOUT, 1000, max idle clocks between bytes inside a frame; 0 disables

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
byte_available  in  1  one-cycle strobe, byte valid
byte  in  8  received ASCII character
command  out  4*CMD_NIBBLES  decoded command
address  out  4*ADDR_NIBBLES  decoded address
data  out  4*DATA_NIBBLES  current decoded data word
data_count  out  4*COUNT_NIBBLES  words remaining after the current one
ready  out  1  one-cycle pulse: command/address/data/data_count valid
error  out  1  one-cycle pulse on frame abort
error_code  out  2  1=non-hex, 2=timeout, 3=resync; holds until next error
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst low at posedge clk): all outputs 0, state IDLE, counters 0. Applies mid-frame; partial frame discarded, no ready/error.
- Only the clk in which byte_available=1 consumes a byte. At most one byte per clock.
- Hex decode: '0'-'9', 'A'-'F', 'a'-'f' -> 0..15; anything else is non-hex.
- Fields shifted in MSB-first: field <= {field[W-5:0], nibble}. Nibble counter counts to field's NIBBLES, then state advances.
- States: IDLE -> COUNT -> COMMAND -> ADDRESS -> DATA -> (DATA | IDLE).
- IDLE: START_CHAR -> clear command/address/data/data_count, go COUNT. All other bytes (including CR/LF) ignored silently.
- COUNT/COMMAND/ADDRESS/DATA: hex byte shifts in. Last nibble of DATA completes a word.
- Word complete: in the next cycle ready=1 for exactly one clock, with data_count = remaining words. If remaining > 0, decrement the internal remaining counter, clear the data shift register, stay in DATA. If remaining = 0, go IDLE. Command and address are unchanged across burst words.
- Total words per frame = count field + 1. A count of all-ones is legal; there is no wrap-around, so it decrements to 0.
- Outputs hold their last values between ready pulses. They are not cleared at the end of a frame, only at the next START_CHAR.
- Non-hex byte in a frame (other than START_CHAR): error pulse, error_code=1, go IDLE.
- START_CHAR mid-frame: error pulse, error_code=3, clear fields, go COUNT (new frame begins).
- Timeout: the counter clears on every consumed byte and on entry to IDLE, and increments each clock while not IDLE. When it reaches TIMEOUT: error pulse, error_code=2, go IDLE. If byte_available arrives in the same cycle, the byte wins: it is processed and the counter clears. TIMEOUT=0 means never.
- ready and error are never asserted in the same cycle. ready latency: 1 clock after the strobe carrying the final nibble.

Test Plan:
- Default params, send "L0000000" "00000001" "12345678" "DEADBEEF", strobes 6 clocks apart -> single ready pulse 1 clk after last strobe; command=00000001, address=12345678, data=DEADBEEF, data_count=0; busy low afterwards; no error.
- Burst: "L0000002" "00000002" "00001000" then "00000011" "00000022" "00000033" -> three ready pulses, data=11/22/33 with data_count=2/1/0; address=00001000 on all three.
- Lowercase plus noise: "\r\nxL0000000" "0000000a" "ffffffff" "cafef00d" -> leading bytes ignored, ready with command=0000000A, address=FFFFFFFF, data=CAFEF00D.
- Non-hex 'G' as third command digit -> error pulse, error_code=1, busy low, no ready. A following valid frame parses correctly.
- TIMEOUT=20: send "L00" then stop -> error pulse exactly 20 clocks after the last strobe, error_code=2. Repeat with a byte strobed on the 20th cycle -> no error.
- 'L' in mid-address -> error_code=3, then a complete frame following it yields a correct ready. Separately, drive rst low mid-data-word -> all outputs 0, and the next full frame parses correctly.
